// File: rtl/data_mem_resp.sv
// Multicycle word-addressed data memory responder with programmable completion latency.
// Optional build macro DATA_MEM_RESP_CLEAR_EN adds a post-reset INIT sweep that zeroes memory.
module data_mem_resp #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        misaligned
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef DATA_MEM_RESP_CLEAR_EN
  localparam logic [1:0] S_INIT = 2'd3;
  localparam logic [1:0] S_RESET = S_INIT;
`else
  localparam logic [1:0] S_RESET = S_IDLE;
`endif

  logic [1:0]            state;
  logic [3:0]            count;
  logic                  op_write;
  logic                  op_read;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [1:0]            off_q;
  logic [31:0]           data_q;
  logic [31:0]           mem [DEPTH];

`ifdef DATA_MEM_RESP_CLEAR_EN
  logic [DEPTH_LOG2-1:0] sweep;
`endif

  logic                  req;
  logic                  accept;
  logic                  complete;
  logic                  c_write;
  logic                  c_read;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [1:0]            c_off;
  logic [31:0]           c_data;
  logic                  mem_we;
  logic                  unused_addr;

  assign req         = MemRead | MemWrite;
  assign accept      = (state == S_IDLE) && req;
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  // With a single-cycle latency the access completes on its acceptance edge,
  // so the live request is used instead of the captured copy.
  always_comb begin
    complete = 1'b0;
    c_write  = op_write;
    c_read   = op_read;
    c_idx    = idx_q;
    c_off    = off_q;
    c_data   = data_q;
    if (LATENCY == 1) begin
      complete = accept;
      c_write  = MemWrite;
      c_read   = MemRead & ~MemWrite;
      c_idx    = addr[DEPTH_LOG2+1:2];
      c_off    = addr[1:0];
      c_data   = write_data;
    end else begin
      complete = (state == S_WAIT) && (count == 4'd0);
    end
  end

  // Gating by rst_n keeps an access aborted by reset from landing in memory.
  assign mem_we = rst_n && complete && c_write && (c_off == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET;
      count     <= 4'd0;
      op_write  <= 1'b0;
      op_read   <= 1'b0;
      idx_q     <= '0;
      off_q     <= 2'b00;
      data_q    <= 32'd0;
      read_data <= 32'd0;
`ifdef DATA_MEM_RESP_CLEAR_EN
      sweep     <= '0;
`endif
    end else begin
      if (complete && c_read && (c_off == 2'b00)) begin
        read_data <= mem[c_idx];
      end
      case (state)
`ifdef DATA_MEM_RESP_CLEAR_EN
        S_INIT: begin
          sweep <= sweep + DEPTH_LOG2'(1);
          if (sweep == '1) begin
            state <= S_IDLE;
          end
        end
`endif
        S_IDLE: begin
          if (req) begin
            op_write <= MemWrite;
            op_read  <= MemRead & ~MemWrite;
            idx_q    <= addr[DEPTH_LOG2+1:2];
            off_q    <= addr[1:0];
            data_q   <= write_data;
            count    <= LAT_LOAD;
            state    <= (LATENCY == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (count == 4'd0) begin
            state <= S_DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
`ifdef DATA_MEM_RESP_CLEAR_EN
    if (rst_n && (state == S_INIT)) begin
      mem[sweep] <= 32'd0;
    end else if (mem_we) begin
      mem[c_idx] <= c_data;
    end
`else
    if (mem_we) begin
      mem[c_idx] <= c_data;
    end
`endif
  end

  assign ready      = (state == S_DONE);
  assign misaligned = (state == S_DONE) && (off_q != 2'b00);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed vector table, reset/clear corner cases,
// then randomized accesses checked against an array-based memory model.
module tb_data_mem_resp;

  localparam int DEPTH_LOG2 = 8;
  localparam int LATENCY    = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        busy;
  logic        misaligned;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_known [DEPTH];
  logic [31:0] model_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [11];

  data_mem_resp #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .busy       (busy),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Memory contents survive reset unless the clear sweep is built in.
  function automatic void model_reset();
    model_rd = 32'd0;
`ifdef DATA_MEM_RESP_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = 32'd0;
      model_known[i] = 1'b1;
    end
`endif
  endfunction

  function automatic void model_apply(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[DEPTH_LOG2+1:2]);
    if (a[1:0] == 2'b00) begin
      if (wr) begin
        model_mem[idx]   = d;
        model_known[idx] = 1'b1;
      end else if (rd) begin
        model_rd = model_mem[idx];
      end
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_rdata, input logic exp_mis,
                               input bit toggle);
    int          nready;
    int          first;
    logic [31:0] cap_rd;
    logic        cap_mis;
    wait_idle();
    MemRead    = rd;
    MemWrite   = wr;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    MemRead    = toggle;
    addr       = $urandom();
    write_data = $urandom();
    nready  = 0;
    first   = 0;
    cap_rd  = 32'd0;
    cap_mis = 1'b0;
    for (int k = 1; k <= LATENCY + 1; k++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        nready++;
        if (first == 0) first = k;
        cap_rd  = read_data;
        cap_mis = misaligned;
      end
      checkOutput($sformatf("%s/busy%0d", name, k), {31'd0, busy}, (k <= LATENCY) ? 32'd1 : 32'd0);
      if (toggle && busy) MemRead = ~MemRead;
      else MemRead = 1'b0;
    end
    checkOutput({name, "/ready_count"}, nready, 1);
    checkOutput({name, "/ready_cycle"}, first, LATENCY);
    checkOutput({name, "/read_data"}, cap_rd, exp_rdata);
    checkOutput({name, "/misaligned"}, {31'd0, cap_mis}, {31'd0, exp_mis});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        wr;
    int          idx;
    int          op;
    int          n;

    rst_n      = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    addr       = 32'd0;
    write_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = 32'd0;
      model_known[i] = 1'b0;
    end
    model_reset();

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hA5A5_A5A5, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hA5A5_A5A5, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FC04, 32'h0BAD_F00D, 32'h1234_5678, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/ready", {31'd0, ready}, 32'd0);
    checkOutput("reset/misaligned", {31'd0, misaligned}, 32'd0);
    checkOutput("reset/read_data", read_data, 32'd0);
`ifdef DATA_MEM_RESP_CLEAR_EN
    checkOutput("reset/busy", {31'd0, busy}, 32'd1);
`else
    checkOutput("reset/busy", {31'd0, busy}, 32'd0);
`endif
    rst_n = 1'b1;

`ifdef DATA_MEM_RESP_CLEAR_EN
    n = 0;
    while (busy === 1'b1 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("clear/busy_cycles", n, DEPTH);
    applyStimulus("clear/read_3fc", 1'b1, 1'b0, 32'h0000_03FC, 32'd0, 32'd0, 1'b0, 1'b0);
    model_apply(1'b1, 1'b0, 32'h0000_03FC, 32'd0);
`else
    #1;
    checkOutput("release/busy", {31'd0, busy}, 32'd0);
`endif

    for (int i = 0; i < 11; i++) begin
      model_apply(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
      applyStimulus($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
                    vecs[i].exp_rdata, vecs[i].exp_mis, (i % 2) == 0);
    end

    // Abort a write to 0x20 while it is waiting out its latency.
    wait_idle();
    MemWrite   = 1'b1;
    addr       = 32'h0000_0020;
    write_data = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort/ready", {31'd0, ready}, 32'd0);
    checkOutput("abort/misaligned", {31'd0, misaligned}, 32'd0);
    checkOutput("abort/read_data", read_data, 32'd0);
`ifdef DATA_MEM_RESP_CLEAR_EN
    checkOutput("abort/busy", {31'd0, busy}, 32'd1);
`else
    checkOutput("abort/busy", {31'd0, busy}, 32'd0);
`endif
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) n++;
    end
    checkOutput("abort/no_ready", n, 0);
    rst_n = 1'b1;
    model_reset();
    model_apply(1'b1, 1'b0, 32'h0000_0020, 32'd0);
    applyStimulus("abort/read_20", 1'b1, 1'b0, 32'h0000_0020, 32'd0, model_rd, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 15);
      op  = $urandom_range(0, 2);
      a   = $urandom();
      a[DEPTH_LOG2+1:2] = DEPTH_LOG2'(idx);
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d   = $urandom();
      wr  = (op != 1);
      rd  = (op != 0);
      if (rd && !wr && a[1:0] == 2'b00 && !model_known[idx]) begin
        rd = 1'b0;
        wr = 1'b1;
      end
      model_apply(rd, wr, a, d);
      applyStimulus($sformatf("rand%0d", i), rd, wr, a, d, model_rd, a[1:0] != 2'b00,
                    $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
